// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Included by the arbiter top and its starvation-guard sub-module.
package dmem_arb_pkg;

    localparam int DMEM_ADDR_W = 12;
    localparam int DMEM_DATA_W = 32;

    typedef enum logic {
        NORMAL,
        STARVE
    } arb_mode_t;

    typedef enum logic {
        PORT_C,
        PORT_D
    } port_id_t;

endpackage

// File: rtl/dmem_arb_starve.sv
// Starvation guard: counts denied display-port cycles and flips
// arbitration priority to port D once the wait limit is reached.
module dmem_arb_starve
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      d_req,
    input  logic      d_gnt,
    output arb_mode_t mode
);

    localparam logic [7:0] LIM = 8'(MAX_WAIT - 1);

    logic [7:0] wait_cnt;
    arb_mode_t  mode_q;
    arb_mode_t  mode_d;
    logic       denied;
    logic       at_lim;

    assign denied = d_req & ~d_gnt;
    assign at_lim = (wait_cnt == LIM);
    assign mode   = mode_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (!denied) begin
            wait_cnt <= '0;
        end else if (!at_lim) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_q <= NORMAL;
        end else begin
            mode_q <= mode_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        unique case (mode_q)
            NORMAL: if (denied && at_lim) mode_d = STARVE;
            STARVE: if (d_gnt) mode_d = NORMAL;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port dmem arbiter: processor port C (priority) vs display
// port D, with read tagging and last-write debug capture.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int MAX_WAIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              c_req,
    input  logic              d_req,
    input  logic              c_we,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] c_wdata,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              c_gnt,
    output logic              d_gnt,
    output logic              c_rvalid,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    arb_mode_t mode;
    port_id_t  sel;
    logic      c_tag;
    logic      d_tag;

    dmem_arb_starve #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clock (clock),
        .reset (reset),
        .d_req (d_req),
        .d_gnt (d_gnt),
        .mode  (mode)
    );

    // Grants are gated by reset so nothing reaches dmem while held.
    assign c_gnt = reset & c_req & ((mode == NORMAL) | ~d_req);
    assign d_gnt = reset & d_req & ((mode == STARVE) | ~c_req);

    assign sel = d_gnt ? PORT_D : PORT_C;

    always_comb begin
        mem_addr  = c_addr;
        mem_wdata = c_wdata;
        unique case (sel)
            PORT_C: begin
                mem_addr  = c_addr;
                mem_wdata = c_wdata;
            end
            PORT_D: begin
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end
        endcase
    end

    assign mem_wren = (c_gnt & c_we) | (d_gnt & d_we);
    assign rdata    = mem_q;
    assign c_rvalid = c_tag;
    assign d_rvalid = d_tag;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            c_tag <= 1'b0;
            d_tag <= 1'b0;
        end else begin
            c_tag <= c_gnt & ~c_we;
            d_tag <= d_gnt & ~d_we;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dbg_addr <= '0;
            dbg_data <= '0;
        end else if (mem_wren) begin
            dbg_addr <= mem_addr;
            dbg_data <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1-cycle dmem.
// Vector table for per-cycle behaviour plus hand-written sequences.
module tb_dmem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          c_req = 1'b0;
    logic          d_req = 1'b0;
    logic          c_we = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] c_addr = '0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] c_wdata = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          c_gnt;
    logic          d_gnt;
    logic          c_rvalid;
    logic          d_rvalid;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wren;
    logic [DW-1:0] mem_q = '0;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;

    int checks = 0;
    int failures = 0;

    dmem_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_WAIT (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .c_req     (c_req),
        .d_req     (d_req),
        .c_we      (c_we),
        .d_we      (d_we),
        .c_addr    (c_addr),
        .d_addr    (d_addr),
        .c_wdata   (c_wdata),
        .d_wdata   (d_wdata),
        .c_gnt     (c_gnt),
        .d_gnt     (d_gnt),
        .c_rvalid  (c_rvalid),
        .d_rvalid  (d_rvalid),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wren  (mem_wren),
        .mem_q     (mem_q),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    always #5 clock = ~clock;

    // Unwritten words read back as 0xA500_0000 | addr.
    logic [DW-1:0] mem [4096];
    bit            wr_seen [4096];

    always @(posedge clock) begin
        if (mem_wren) begin
            mem[mem_addr]     <= mem_wdata;
            wr_seen[mem_addr] <= 1'b1;
        end
        mem_q <= wr_seen[mem_addr] ? mem[mem_addr]
                                   : {20'hA5000, mem_addr};
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cr, input logic cw,
                         input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                         input logic dr, input logic dw,
                         input logic [AW-1:0] da, input logic [DW-1:0] dd);
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    endtask

    typedef struct {
        logic          cr, cw;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        logic          dr, dw;
        logic [AW-1:0] da;
        logic [DW-1:0] dd;
        logic          ecg, edg, ewr, ecrv, edrv;
        logic [AW-1:0] ema;
        logic          chkd;
        logic [DW-1:0] erd;
    } vec_t;

    vec_t tv [10];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // cr cw ca cd | dr dw da dd | cg dg wr crv drv | ma chk rd
        tv[0] = '{1,1,12'h010,32'hDEADBEEF, 0,0,12'h000,0,
                  1,0,1,0,0, 12'h010, 0, 0};
        tv[1] = '{1,0,12'h010,0, 0,0,12'h000,0,
                  1,0,0,0,0, 12'h010, 0, 0};
        tv[2] = '{0,0,12'h000,0, 0,0,12'h000,0,
                  0,0,0,1,0, 12'h000, 1, 32'hDEADBEEF};
        tv[3] = '{1,0,12'h005,0, 1,0,12'h010,0,
                  1,0,0,0,0, 12'h005, 0, 0};
        tv[4] = '{0,0,12'h000,0, 1,0,12'h010,0,
                  0,1,0,1,0, 12'h010, 1, 32'hA5000005};
        tv[5] = '{1,0,12'h020,0, 0,0,12'h000,0,
                  1,0,0,0,1, 12'h020, 1, 32'hDEADBEEF};
        tv[6] = '{0,0,12'h000,0, 1,0,12'h800,0,
                  0,1,0,1,0, 12'h800, 1, 32'hA5000020};
        tv[7] = '{1,1,12'h030,32'h12345678, 0,0,12'h000,0,
                  1,0,1,0,1, 12'h030, 1, 32'hA5000800};
        tv[8] = '{0,0,12'h000,0, 1,0,12'h030,0,
                  0,1,0,0,0, 12'h030, 0, 0};
        tv[9] = '{0,0,12'h000,0, 0,0,12'h000,0,
                  0,0,0,0,1, 12'h000, 1, 32'h12345678};

        // Reset held: requests present but nothing may be granted.
        drive(1, 1, 12'h00A, 32'h55, 1, 1, 12'h00B, 32'h66);
        @(posedge clock); #1;
        chk("rst_cgnt", c_gnt, 0);
        chk("rst_dgnt", d_gnt, 0);
        chk("rst_wren", mem_wren, 0);
        chk("rst_rvalid", {c_rvalid, d_rvalid}, 0);
        chk("rst_dbg", {dbg_addr, dbg_data}, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;

        foreach (tv[i]) begin
            @(posedge clock); #1;
            drive(tv[i].cr, tv[i].cw, tv[i].ca, tv[i].cd,
                  tv[i].dr, tv[i].dw, tv[i].da, tv[i].dd);
            #4;
            chk($sformatf("v%0d.cgnt", i), c_gnt, tv[i].ecg);
            chk($sformatf("v%0d.dgnt", i), d_gnt, tv[i].edg);
            chk($sformatf("v%0d.wren", i), mem_wren, tv[i].ewr);
            chk($sformatf("v%0d.crv", i), c_rvalid, tv[i].ecrv);
            chk($sformatf("v%0d.drv", i), d_rvalid, tv[i].edrv);
            chk($sformatf("v%0d.maddr", i), mem_addr, tv[i].ema);
            if (tv[i].chkd)
                chk($sformatf("v%0d.rdata", i), rdata, tv[i].erd);
        end
        chk("dbg_addr", dbg_addr, 12'h030);
        chk("dbg_data", dbg_data, 32'h12345678);

        // Starvation: C holds reads, D waits 8 cycles then wins once.
        for (int n = 1; n <= 8; n++) begin
            @(posedge clock); #1;
            drive(1, 0, 12'h001, 0, 1, 0, 12'h800, 0);
            #4;
            chk($sformatf("stv%0d.cgnt", n), c_gnt, 1);
            chk($sformatf("stv%0d.dgnt", n), d_gnt, 0);
        end
        @(posedge clock); #5;
        chk("stv9.dgnt", d_gnt, 1);
        chk("stv9.cgnt", c_gnt, 0);
        chk("stv9.maddr", mem_addr, 12'h800);
        @(posedge clock); #1;
        drive(1, 0, 12'h001, 0, 1, 0, 12'h010, 0);
        #4;
        chk("stv10.drv", d_rvalid, 1);
        chk("stv10.crv", c_rvalid, 0);
        chk("stv10.rdata", rdata, 32'hA5000800);
        chk("stv10.normal_cgnt", c_gnt, 1);
        chk("stv10.normal_dgnt", d_gnt, 0);

        // Idle stretch.
        for (int n = 0; n < 20; n++) begin
            @(posedge clock); #1;
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            #4;
            chk($sformatf("idle%0d", n), {c_gnt, d_gnt, mem_wren}, 0);
        end
        chk("idle.wait_cnt", dut.u_starve.wait_cnt, 0);
        chk("idle.dbg_addr", dbg_addr, 12'h030);
        chk("idle.dbg_data", dbg_data, 32'h12345678);

        // Reset in the cycle after a granted read kills its rvalid.
        @(posedge clock); #1;
        drive(1, 0, 12'h005, 0, 0, 0, 0, 0);
        #4;
        chk("rmr.cgnt", c_gnt, 1);
        @(posedge clock); #1;
        drive(1, 1, 12'h007, 32'h99, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        chk("rmr.crv", c_rvalid, 0);
        chk("rmr.dbg_addr", dbg_addr, 0);
        chk("rmr.dbg_data", dbg_data, 0);
        chk("rmr.cgnt_held", c_gnt, 0);
        chk("rmr.wren_held", mem_wren, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        drive(1, 0, 12'h005, 0, 0, 0, 0, 0);
        #4;
        chk("post_rst.cgnt", c_gnt, 1);
        @(posedge clock); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #4;
        chk("post_rst.crv", c_rvalid, 1);
        chk("post_rst.rdata", rdata, 32'hA5000005);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
